a2d_spi_model: RTL and testbench
================================

Name: a2d_spi_model

Overview:
- Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter at the far end of the A2D SPI bus.
- Used in benches and on the FPGA loopback build to exercise the A2D SPI master without the physical chip.
- Receives a 3-bit channel address on MOSI during one 16-bit frame and returns that channel's 12-bit value on MISO during the next frame.
- Channel values come from a flat input bus.

Parameters:
- NUM_CH, 8, number of analog channels (channel field is 3 bits).
- RES_W, 12, conversion result width.
- FRM_BITS, 16, SCLK edges per frame.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  slave select from master, active low
- SCLK  input  1  serial clock from master, idles high
- MOSI  input  1  command data from master
- MISO  output  1  result data to master
- ana_val  input  96  channel values, channel k = ana_val[12k+11:12k]
- chnnl_sel  output  3  channel address latched from the last good frame
- frm_cnt  output  8  count of good frames, wraps 255->0
- frm_err  output  1  sticky flag: a frame ended with a bit count other than 16

Behaviour:
- Reset values:
  - MISO=0, chnnl_sel=0, frm_cnt=0, frm_err=0.
  - Shift registers=0, bit count=0.
  - Synchronizer flops: SS_n and SCLK reset to 1, MOSI resets to 0.
- Input synchronization:
  - SS_n, SCLK and MOSI each pass through 2 flops plus 1 history flop.
  - Edges are detected on the synchronized versions only.
  - SCLK high and low phases are each at least 4 clk cycles (master runs at clk/32); faster SCLK is out of spec.
- SPI mode:
  - SCLK idles high.
  - Master changes MOSI on SCLK fall and samples MISO on SCLK rise.
  - This block mirrors that: it samples MOSI on synchronized SCLK rise and advances MISO on synchronized SCLK fall.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronized SS_n fall. In that same cycle:
    - tx_shft = {4'b0000, ana_val[chnnl_sel]} (16 bits).
    - bit_cnt = 0.
    - rx_shft is left unchanged.
  - ACTIVE, SCLK rise:
    - rx_shft = {rx_shft[14:0], MOSI_sync}.
    - bit_cnt increments, saturating at 31.
  - ACTIVE, SCLK fall:
    - tx_shft = {tx_shft[14:0], 1'b0}, but only when bit_cnt != 0.
    - The initial fall preceding the first rise does not shift.
  - ACTIVE -> IDLE on synchronized SS_n rise:
    - If bit_cnt == 16: chnnl_sel = rx_shft[13:11] and frm_cnt += 1.
    - Otherwise: frm_err = 1; chnnl_sel and frm_cnt hold.
- MISO = tx_shft[15] while in ACTIVE, else 0. MISO is a registered output.
- Latency:
  - A frame returns ana_val for the channel addressed in the previous good frame.
  - ana_val is sampled once, at SS_n fall; changes mid-frame do not affect the frame.
- Master read sequence: frame 1 carries {2'b00, ch, 11'h000}; frame 2 returns {4'b0, value}.
- Bits 15:14 and 10:0 of the command are ignored.
- SCLK edges while in IDLE are ignored.
- SS_n rise and SCLK edge detected in the same clk cycle: SS_n rise wins and the SCLK edge is dropped.
- Async reset mid-frame:
  - All state clears immediately and the block enters IDLE.
  - If SS_n is still low after reset, no frame starts until a fresh SS_n fall.
- frm_err clears only on reset.

Decomposition:
- Package a2d_spi_pkg holds:
  - constants CH_W=3, RES_W=12, FRM_BITS=16, CMD_CH_MSB=13, CMD_CH_LSB=11;
  - typedef enum logic {IDLE, ACTIVE} spi_state_t.
- One sub-module: spi_in_synch (3-flop synchronizer with rise/fall pulse outputs), instantiated for SS_n and SCLK.
- MOSI uses a plain 2-flop synchronizer.

Test Plan:
- Reset, then ana_val ch0=12'h123. Frame with cmd 16'h2800 (ch5) -> MISO bits 16'h0123, chnnl_sel=5, frm_cnt=1.
- ch5 set to 12'hABC. Next frame with cmd 16'h0000 -> MISO 16'h0ABC, chnnl_sel=0, frm_cnt=2.
- Sweep channels 0..7 with ch k value = 12'h100*k+k, back-to-back frames -> each frame returns the previous channel's value, no frm_err.
- Abort a frame after 9 SCLK cycles (SS_n rises) -> frm_err=1, chnnl_sel and frm_cnt unchanged; next full frame still returns the correct value.
- Change ana_val[ch] mid-frame -> the frame returns the value present at SS_n fall.
- Assert rst_n low at bit 7 of a frame, release it with SS_n still low -> MISO=0, chnnl_sel=0; SCLK edges are ignored until SS_n toggles high then low.

Source files
------------

// File: rtl/a2d_spi_pkg.sv
// rtl/a2d_spi_pkg.sv - shared constants and state type for the A2D SPI responder model
package a2d_spi_pkg;
    localparam int CH_W       = 3;
    localparam int RES_W      = 12;
    localparam int FRM_BITS   = 16;
    localparam int CMD_CH_MSB = 13;
    localparam int CMD_CH_LSB = 11;
    localparam int CNT_W      = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;
endpackage

// File: rtl/spi_in_synch.sv
// rtl/spi_in_synch.sv - 2-flop synchronizer plus history flop with rise/fall pulse outputs
module spi_in_synch #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic       r_meta;
    logic       r_sync;
    logic       r_hist;
    logic [1:0] r_settle;
    logic       w_settled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= RST_VAL;
            r_sync   <= RST_VAL;
            r_hist   <= RST_VAL;
            r_settle <= 2'd0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // The reset value flushing out of the pipe is not a real edge, so pulses are held off until it has.
    assign w_settled = (r_settle == 2'd3);
    assign o_rise    = w_settled &  r_sync & ~r_hist;
    assign o_fall    = w_settled & ~r_sync &  r_hist;
endmodule

// File: rtl/a2d_spi_model.sv
// rtl/a2d_spi_model.sv - SPI responder modelling an 8-channel 12-bit A2D; returns the channel addressed in the previous frame
module a2d_spi_model #(
    parameter int NUM_CH   = 8,
    parameter int RES_W    = a2d_spi_pkg::RES_W,
    parameter int FRM_BITS = a2d_spi_pkg::FRM_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        SS_n,
    input  logic                        SCLK,
    input  logic                        MOSI,
    output logic                        MISO,
    input  logic [NUM_CH*RES_W-1:0]     ana_val,
    output logic [a2d_spi_pkg::CH_W-1:0] chnnl_sel,
    output logic [7:0]                  frm_cnt,
    output logic                        frm_err
);
    import a2d_spi_pkg::spi_state_t;
    import a2d_spi_pkg::IDLE;
    import a2d_spi_pkg::ACTIVE;
    import a2d_spi_pkg::CH_W;
    import a2d_spi_pkg::CNT_W;
    import a2d_spi_pkg::CMD_CH_MSB;
    import a2d_spi_pkg::CMD_CH_LSB;

    logic                r_mosi_meta;
    logic                r_mosi_sync;
    logic                w_ss_rise;
    logic                w_ss_fall;
    logic                w_sclk_rise;
    logic                w_sclk_fall;

    spi_state_t          r_state;
    spi_state_t          w_state_nxt;
    logic [FRM_BITS-1:0] r_tx_shft;
    logic [FRM_BITS-1:0] w_tx_nxt;
    logic [FRM_BITS-1:0] r_rx_shft;
    logic [FRM_BITS-1:0] w_rx_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic [CH_W-1:0]     r_chnnl_sel;
    logic [CH_W-1:0]     w_chnnl_nxt;
    logic [7:0]          r_frm_cnt;
    logic [7:0]          w_frm_cnt_nxt;
    logic                r_frm_err;
    logic                w_frm_err_nxt;
    logic                r_miso;
    logic [RES_W-1:0]    w_sel_val;

    spi_in_synch #(.RST_VAL(1'b1)) u_ss_synch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (SS_n),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_in_synch #(.RST_VAL(1'b1)) u_sclk_synch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (SCLK),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= MOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sel_val = ana_val[r_chnnl_sel*RES_W +: RES_W];

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx_shft;
        w_rx_nxt      = r_rx_shft;
        w_bit_cnt_nxt = r_bit_cnt;
        w_chnnl_nxt   = r_chnnl_sel;
        w_frm_cnt_nxt = r_frm_cnt;
        w_frm_err_nxt = r_frm_err;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt   = ACTIVE;
                    w_tx_nxt      = {{(FRM_BITS-RES_W){1'b0}}, w_sel_val};
                    w_bit_cnt_nxt = '0;
                end
            end
            ACTIVE: begin
                // SS_n rise takes priority; a coincident SCLK edge is dropped.
                if (w_ss_rise) begin
                    w_state_nxt = IDLE;
                    if (r_bit_cnt == CNT_W'(FRM_BITS)) begin
                        w_chnnl_nxt   = r_rx_shft[CMD_CH_MSB:CMD_CH_LSB];
                        w_frm_cnt_nxt = r_frm_cnt + 8'd1;
                    end else begin
                        w_frm_err_nxt = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    w_rx_nxt = {r_rx_shft[FRM_BITS-2:0], r_mosi_sync};
                    if (r_bit_cnt != '1) begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    w_tx_nxt = {r_tx_shft[FRM_BITS-2:0], 1'b0};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tx_shft   <= '0;
            r_rx_shft   <= '0;
            r_bit_cnt   <= '0;
            r_chnnl_sel <= '0;
            r_frm_cnt   <= '0;
            r_frm_err   <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_shft   <= w_tx_nxt;
            r_rx_shft   <= w_rx_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_chnnl_sel <= w_chnnl_nxt;
            r_frm_cnt   <= w_frm_cnt_nxt;
            r_frm_err   <= w_frm_err_nxt;
            r_miso      <= (w_state_nxt == ACTIVE) ? w_tx_nxt[FRM_BITS-1] : 1'b0;
        end
    end

    assign MISO      = r_miso;
    assign chnnl_sel = r_chnnl_sel;
    assign frm_cnt   = r_frm_cnt;
    assign frm_err   = r_frm_err;
endmodule

// File: tb/tb_a2d_spi_model.sv
// tb/tb_a2d_spi_model.sv - scoreboard bench for the A2D SPI responder model
module tb_a2d_spi_model;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ana_val;
    logic [2:0]  chnnl_sel;
    logic [7:0]  frm_cnt;
    logic        frm_err;

    typedef struct {
        logic [15:0] miso;
        logic [15:0] mask;
        logic [2:0]  ch;
        logic [7:0]  cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    a2d_spi_model dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .ana_val   (ana_val),
        .chnnl_sel (chnnl_sel),
        .frm_cnt   (frm_cnt),
        .frm_err   (frm_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ana_val[k*12 +: 12] = v;
    endtask

    // One master frame; chg_at rewrites channel 4 at that bit, rst_at pulses rst_n at that bit.
    task automatic frame(input logic [15:0] cmd, input int nbits, input exp_t e,
                         input int chg_at, input int rst_at);
        exp_q.push_back(e);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) set_ch(4, 12'hFED);
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                check("rst_miso", {31'b0, MISO}, 32'd0);
                check("rst_chnnl_sel", {29'b0, chnnl_sel}, 32'd0);
                check("rst_frm_cnt", {24'b0, frm_cnt}, 32'd0);
                check("rst_frm_err", {31'b0, frm_err}, 32'd0);
            end
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (16) @(negedge clk);
            SCLK = 1'b1;
            repeat (15) @(negedge clk);
        end
        SS_n = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] word;
        int          bits;
        word = '0;
        bits = 0;
        forever begin
            @(posedge SCLK or posedge SS_n);
            if (SS_n === 1'b0) begin
                word = {word[14:0], MISO};
                bits++;
            end else if (SS_n === 1'b1 && bits > 0) begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("queue_underrun", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.mask != 16'h0000)
                        check("miso_word", {16'b0, word & e.mask}, {16'b0, e.miso & e.mask});
                    check("chnnl_sel", {29'b0, chnnl_sel}, {29'b0, e.ch});
                    check("frm_cnt", {24'b0, frm_cnt}, {24'b0, e.cnt});
                    check("frm_err", {31'b0, frm_err}, {31'b0, e.err});
                end
                word = '0;
                bits = 0;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] sw_cmd [9];
        logic [15:0] sw_miso[9];
        logic [2:0]  sw_ch  [9];
        logic [7:0]  sw_cnt [9];
        sw_cmd  = '{16'h0000, 16'h0800, 16'hD5A5, 16'h1800, 16'h2000, 16'h2800, 16'h3000, 16'h7801, 16'h1800};
        sw_miso = '{16'h0000, 16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707};
        sw_ch   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        sw_cnt  = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};

        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        ana_val = '0;
        set_ch(0, 12'h123);
        repeat (3) @(negedge clk);
        check("reset_miso", {31'b0, MISO}, 32'd0);
        check("reset_chnnl_sel", {29'b0, chnnl_sel}, 32'd0);
        check("reset_frm_cnt", {24'b0, frm_cnt}, 32'd0);
        check("reset_frm_err", {31'b0, frm_err}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        frame(16'h2800, 16, '{16'h0123, 16'hFFFF, 3'd5, 8'd1, 1'b0}, -1, -1);
        set_ch(5, 12'hABC);
        frame(16'h0000, 16, '{16'h0ABC, 16'hFFFF, 3'd0, 8'd2, 1'b0}, -1, -1);

        for (int k = 0; k < 8; k++) set_ch(k, 12'(12'h101 * k));
        for (int i = 0; i < 9; i++)
            frame(sw_cmd[i], 16, '{sw_miso[i], 16'hFFFF, sw_ch[i], sw_cnt[i], 1'b0}, -1, -1);

        frame(16'h3800, 9, '{16'h0000, 16'h0000, 3'd3, 8'd11, 1'b1}, -1, -1);
        frame(16'h2000, 16, '{16'h0303, 16'hFFFF, 3'd4, 8'd12, 1'b1}, -1, -1);

        frame(16'h0800, 16, '{16'h0404, 16'hFFFF, 3'd1, 8'd13, 1'b1}, 5, -1);
        frame(16'h2000, 16, '{16'h0101, 16'hFFFF, 3'd4, 8'd14, 1'b1}, -1, -1);
        frame(16'h0000, 16, '{16'h0FED, 16'hFFFF, 3'd0, 8'd15, 1'b1}, -1, -1);

        frame(16'h2800, 16, '{16'h0000, 16'h01FF, 3'd0, 8'd0, 1'b0}, -1, 7);
        set_ch(0, 12'h5A5);
        frame(16'h1000, 16, '{16'h05A5, 16'hFFFF, 3'd2, 8'd1, 1'b0}, -1, -1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
